// File: rtl/lc3b_types.sv
// Shared LC-3b types; this slice adds the branch predictor counter type,
// its reset/allocation constants and the per-entry counter operation.
package lc3b_types;

  typedef logic [1:0] lc3b_bp_ctr;

  localparam lc3b_bp_ctr BP_CTR_RESET = 2'b01;
  localparam lc3b_bp_ctr BP_CTR_ALLOC = 2'b10;

  typedef enum logic [1:0] {
    CTR_HOLD,
    CTR_INC,
    CTR_DEC,
    CTR_LOAD
  } lc3b_bp_ctr_op;

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating up/down counter holding one predictor entry's direction
// history; a load overrides it when an entry is (re)allocated.
module bp_sat_counter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  lc3b_bp_ctr_op op,
  input  lc3b_bp_ctr    load_value,
  output lc3b_bp_ctr    count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= BP_CTR_RESET;
    end else begin
      case (op)
        CTR_INC:  if (count != 2'b11) count <= count + 2'b01;
        CTR_DEC:  if (count != 2'b00) count <= count - 2'b01;
        CTR_LOAD: count <= load_value;
        default:  count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with target buffer and 2-bit counters.
// Define BP_STATS_EN to add the update / mispredict statistics counters.
module branch_predictor
  import lc3b_types::*;
#(
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       lookup_pc,
  output logic              pred_taken,
  output logic [15:0]       pred_target,
  input  logic              upd_valid,
  input  logic [15:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [15:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [15:0]       upd_pred_target,
  output logic              mispredict,
  output logic [15:0]       redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 15 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [15:0]        targets [ENTRIES];
  lc3b_bp_ctr         ctrs    [ENTRIES];
  lc3b_bp_ctr_op      ctr_ops [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[15:IDX_W+1];
  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[15:IDX_W+1];
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  // Reads see the table as it was before this edge's update; there is no bypass.
  assign pred_taken  = lk_hit && ctrs[lk_idx][1];
  assign pred_target = pred_taken ? targets[lk_idx] : lookup_pc + 16'd2;

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 16'd2;

  // A taken resolution either refreshes a hit entry or claims the slot; tags
  // and targets are deliberately left unreset since valid gates them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (upd_valid && upd_taken) begin
      valid[up_idx]   <= 1'b1;
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= upd_target;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_ops[i] = CTR_HOLD;
      if (upd_valid && (up_idx == IDX_W'(i))) begin
        if (up_hit)         ctr_ops[i] = upd_taken ? CTR_INC : CTR_DEC;
        else if (upd_taken) ctr_ops[i] = CTR_LOAD;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : gen_ctr
    bp_sat_counter u_ctr (
      .clk        (clk),
      .reset      (reset),
      .op         (ctr_ops[g]),
      .load_value (BP_CTR_ALLOC),
      .count      (ctrs[g])
    );
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_updates <= stat_updates + STAT_W'(1);
      if (mispredict) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16) using a reference
// table model and an expected/observed scoreboard; BP_STATS_EN adds stat tests.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] lookup_pc = 16'h0;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0;
  logic        upd_pred_taken = 1'b0;
  logic [15:0] upd_pred_target = 16'h0;
  logic        mispredict;
  logic [15:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [16:0] val;
    logic [16:0] mask;
  } sb_t;

  sb_t exp_q[$];
  sb_t obs_q[$];
  sb_t e, o;

  // Reference table model
  logic        m_valid [16];
  logic [10:0] m_tag   [16];
  logic [15:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];
  logic [15:0] m_upd, m_mis;
  logic        last_mis;

  branch_predictor #(.ENTRIES(16), .STAT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
    end
    m_upd = 16'h0;
    m_mis = 16'h0;
  endtask

  function automatic logic [16:0] model_pred(input logic [15:0] pc);
    logic [3:0] idx;
    idx = pc[4:1];
    if (m_valid[idx] && (m_tag[idx] == pc[15:5]) && m_ctr[idx][1])
      return {1'b1, m_tgt[idx]};
    return {1'b0, pc + 16'd2};
  endfunction

  task automatic drive_lookup(input logic [15:0] pc, input string name);
    @(negedge clk);
    lookup_pc = pc;
    exp_q.push_back('{name, model_pred(pc), 17'h1FFFF});
    #1;
    obs_q.push_back('{name, {pred_taken, pred_target}, 17'h1FFFF});
  endtask

  // Drives an update and a same-PC lookup; returns before the capturing edge.
  task automatic drive_update(input logic [15:0] pc, input logic taken,
                              input logic [15:0] tgt, input logic ptaken,
                              input logic [15:0] ptgt, input string name);
    logic [15:0] redir;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = taken;
    upd_target = tgt;
    upd_pred_taken = ptaken;
    upd_pred_target = ptgt;
    lookup_pc = pc;
    last_mis = (taken != ptaken) || (taken && (tgt != ptgt));
    redir = taken ? tgt : pc + 16'd2;
    exp_q.push_back('{{name, "_mis"}, {last_mis, redir},
                      last_mis ? 17'h1FFFF : 17'h10000});
    exp_q.push_back('{{name, "_pred"}, model_pred(pc), 17'h1FFFF});
    #1;
    obs_q.push_back('{{name, "_mis"}, {mispredict, redirect_pc}, 17'h1FFFF});
    obs_q.push_back('{{name, "_pred"}, {pred_taken, pred_target}, 17'h1FFFF});
  endtask

  task automatic commit_update();
    logic [3:0] idx;
    logic       hit;
    @(posedge clk);
    if (!reset) begin
      idx = upd_pc[4:1];
      hit = m_valid[idx] && (m_tag[idx] == upd_pc[15:5]);
      if (hit) begin
        if (upd_taken) begin
          if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'b01;
          m_tgt[idx] = upd_target;
        end else if (m_ctr[idx] != 2'b00) begin
          m_ctr[idx] = m_ctr[idx] - 2'b01;
        end
      end else if (upd_taken) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = upd_pc[15:5];
        m_tgt[idx]   = upd_target;
        m_ctr[idx]   = 2'b10;
      end
      m_upd = m_upd + 16'd1;
      if (last_mis) m_mis = m_mis + 16'd1;
    end
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive_lookup(16'h0040, "reset_lookup");
    checks++;
    if ({pred_taken, pred_target} !== 17'h0_0042) begin
      failures++;
      $display("[TB] FAIL reset_lookup_const: got %h expected %h", {pred_taken, pred_target}, 17'h0_0042);
    end
    drive_update(16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0042, "reset_upd");
    checks++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mispredict: got %b expected 1", mispredict);
    end
    commit_update();
`ifdef BP_STATS_EN
    checks++;
    if ({stat_updates, stat_mispredicts} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_stats: got %h expected 0", {stat_updates, stat_mispredicts});
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_alloc();
    drive_update(16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0042, "alloc_upd");
    checks++;
    if ({mispredict, redirect_pc} !== 17'h1_0100) begin
      failures++;
      $display("[TB] FAIL alloc_redirect: got %h expected %h", {mispredict, redirect_pc}, 17'h1_0100);
    end
    commit_update();
    drive_lookup(16'h0040, "alloc_lookup");
    checks++;
    if ({pred_taken, pred_target} !== 17'h1_0100) begin
      failures++;
      $display("[TB] FAIL alloc_lookup_const: got %h expected %h", {pred_taken, pred_target}, 17'h1_0100);
    end
    drive_lookup(16'h0060, "alias_lookup");
    checks++;
    if ({pred_taken, pred_target} !== 17'h0_0062) begin
      failures++;
      $display("[TB] FAIL alias_lookup_const: got %h expected %h", {pred_taken, pred_target}, 17'h0_0062);
    end
    drive_update(16'h0080, 1'b0, 16'h0300, 1'b0, 16'h0082, "miss_nt_upd");
    commit_update();
    drive_lookup(16'h0080, "miss_nt_lookup");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 3; i++) begin
      drive_update(16'h0040, 1'b1, 16'h0100, 1'b1, 16'h0100, "ctr_taken");
      commit_update();
    end
    drive_update(16'h0040, 1'b0, 16'h0100, 1'b1, 16'h0100, "ctr_nt1");
    checks++;
    if ({mispredict, redirect_pc} !== 17'h1_0042) begin
      failures++;
      $display("[TB] FAIL ctr_nt1_redirect: got %h expected %h", {mispredict, redirect_pc}, 17'h1_0042);
    end
    commit_update();
    drive_lookup(16'h0040, "ctr_after_nt1");
    checks++;
    if ({pred_taken, pred_target} !== 17'h1_0100) begin
      failures++;
      $display("[TB] FAIL ctr_after_nt1_const: got %h expected %h", {pred_taken, pred_target}, 17'h1_0100);
    end
    drive_update(16'h0040, 1'b0, 16'h0100, 1'b1, 16'h0100, "ctr_nt2");
    commit_update();
    drive_lookup(16'h0040, "ctr_after_nt2");
    checks++;
    if ({pred_taken, pred_target} !== 17'h0_0042) begin
      failures++;
      $display("[TB] FAIL ctr_after_nt2_const: got %h expected %h", {pred_taken, pred_target}, 17'h0_0042);
    end
    // Same-index update while the counter sits at 01: the lookup must still see the old state.
    drive_update(16'h0040, 1'b1, 16'h0200, 1'b0, 16'h0042, "no_bypass");
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("[TB] FAIL no_bypass_const: got %b expected 0", pred_taken);
    end
    commit_update();
    drive_lookup(16'h0040, "no_bypass_after");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] pc, tgt;
    logic [16:0] p;
    logic        tk;
    for (int i = 0; i < 60; i++) begin
      pc  = {9'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b0};
      tgt = {15'($urandom()), 1'b0};
      tk  = 1'($urandom_range(0, 1));
      p   = model_pred(pc);
      if ($urandom_range(0, 3) == 0) p[16] = ~p[16];
      drive_update(pc, tk, tgt, p[16], p[15:0], "rand_upd");
      commit_update();
      drive_lookup({9'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b0}, "rand_lookup");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_update(16'h0040, 1'b1, 16'h0500, 1'b0, 16'h0042, "pre_reset_upd");
    commit_update();
    drive_lookup(16'h0040, "pre_reset_lookup");
    checks++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_taken: got %b expected 1", pred_taken);
    end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_drop: got %b expected 0", pred_taken);
    end
    drive_update(16'h0040, 1'b1, 16'h0600, 1'b0, 16'h0042, "reset_mid_upd");
    commit_update();
    @(negedge clk);
    reset = 1'b0;
    drive_lookup(16'h0040, "post_reset_lookup");
    checks++;
    if ({pred_taken, pred_target} !== 17'h0_0042) begin
      failures++;
      $display("[TB] FAIL post_reset_const: got %h expected %h", {pred_taken, pred_target}, 17'h0_0042);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_update(16'h0300, 1'b1, 16'h0400, 1'b0, 16'h0302, "st1"); commit_update();
    drive_update(16'h0300, 1'b1, 16'h0400, 1'b1, 16'h0400, "st2"); commit_update();
    drive_update(16'h0300, 1'b1, 16'h0400, 1'b1, 16'h0400, "st3"); commit_update();
    drive_update(16'h0300, 1'b0, 16'h0400, 1'b1, 16'h0400, "st4"); commit_update();
    drive_update(16'h0500, 1'b0, 16'h0400, 1'b0, 16'h0502, "st5"); commit_update();
    checks++;
    if ({stat_updates, stat_mispredicts} !== {16'd5, 16'd2}) begin
      failures++;
      $display("[TB] FAIL stats_5_2: got %0d/%0d expected 5/2", stat_updates, stat_mispredicts);
    end
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = 16'h0200;
    upd_taken = 1'b0;
    upd_pred_taken = 1'b0;
    repeat (65530) @(posedge clk);
    #1;
    upd_valid = 1'b0;
    m_upd = m_upd + 16'd65530;
    checks++;
    if (stat_updates !== 16'hFFFF || stat_updates !== m_upd) begin
      failures++;
      $display("[TB] FAIL stats_full: got %h expected %h", stat_updates, m_upd);
    end
    drive_update(16'h0200, 1'b0, 16'h0000, 1'b0, 16'h0202, "st_wrap"); commit_update();
    checks++;
    if (stat_updates !== 16'h0000 || stat_mispredicts !== m_mis) begin
      failures++;
      $display("[TB] FAIL stats_wrap: got %h/%h expected 0000/%h", stat_updates, stat_mispredicts, m_mis);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if ((o.val & e.mask) !== (e.val & e.mask)) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, o.val & e.mask, e.val & e.mask);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_random();
    test_async_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
